// File: rtl/digit_serial_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package digit_serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A single-digit configuration still needs a one-bit counter to stay legal.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_sub_digit.sv
// Combinational DIGIT-bit ripple of full-subtractor cells, LSB first.
module sub_digit
    import digit_serial_sub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_k,
    input  logic [DIGIT-1:0] b_k,
    input  logic             bin,
    output logic [DIGIT-1:0] diff_k,
    output logic             bout,
    output logic             msb_bin
);

    logic [DIGIT:0] borrow;

    always_comb begin
        borrow    = '0;
        diff_k    = '0;
        borrow[0] = bin;
        for (int i = 0; i < DIGIT; i++) begin
            diff_k[i]     = a_k[i] ^ b_k[i] ^ borrow[i];
            borrow[i + 1] = (~a_k[i] & b_k[i]) | (~(a_k[i] ^ b_k[i]) & borrow[i]);
        end
    end

    // The borrow entering the top bit is what the signed-overflow flag needs.
    assign bout    = borrow[DIGIT];
    assign msb_bin = borrow[DIGIT-1];

endmodule

// File: rtl/digit_serial_sub.sv
// Multi-cycle A - B - Bin subtractor, DIGIT bits per clock, valid/ready on both sides.
module digit_serial_sub
    import digit_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(NDIG - 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("digit_serial_sub: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;

    logic [DIGIT-1:0]   diff_k;
    logic               borrow_next;
    logic               msb_borrow;
    logic [WIDTH-1:0]   d_full;

    // Operands shift right each digit, so the active digit always sits in the low bits.
    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_k     (a_q[DIGIT-1:0]),
        .b_k     (b_q[DIGIT-1:0]),
        .bin     (borrow_q),
        .diff_k  (diff_k),
        .bout    (borrow_next),
        .msb_bin (msb_borrow)
    );

    // Digits enter at the top of the accumulator; after NDIG steps digit 0 reaches bit 0.
    assign d_full = (WIDTH'(diff_k) << (WIDTH - DIGIT)) | (acc_q >> DIGIT);

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        d_d      = d_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    k_d      = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                acc_d    = d_full;
                borrow_d = borrow_next;
                k_d      = k_q + CNT_W'(1);
                if (k_q == K_LAST) begin
                    state_d = DONE;
                    k_d     = '0;
                    d_d     = d_full;
                    bout_d  = borrow_next;
                    ovf_d   = msb_borrow ^ borrow_next;
                    zero_d  = (d_full == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            d_q      <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            d_q      <= d_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_sub.sv
// Self-checking bench: a 16/4 and an 8/8 instance against an integer-arithmetic reference model.
module tb_digit_serial_sub;

    logic clk;
    logic rst_n;

    logic        in_valid16, in_ready16, bin16, out_valid16, out_ready16;
    logic [15:0] a16, b16, d16;
    logic        bout16, ovf16, zero16;

    logic        in_valid8, in_ready8, bin8, out_valid8, out_ready8;
    logic [7:0]  a8, b8, d8;
    logic        bout8, ovf8, zero8;

    int checks = 0;
    int fails  = 0;

    digit_serial_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .bin(bin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .d(d16), .bout(bout16), .ovf(ovf16), .zero(zero16)
    );

    digit_serial_sub #(.WIDTH(8), .DIGIT(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .d(d8), .bout(bout8), .ovf(ovf8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed integer arithmetic on w-bit operands.
    task automatic refModel(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                            output logic [15:0] ed, output logic eb, output logic eo, output logic ez);
        int mask, ua, ub, sa, sb, full, sfull;
        mask  = (1 << w) - 1;
        ua    = int'(av) & mask;
        ub    = int'(bv) & mask;
        sa    = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb    = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        full  = ua - ub - int'(bi);
        sfull = sa - sb - int'(bi);
        eb    = (full < 0);
        ed    = 16'(full & mask);
        eo    = (sfull > (1 << (w - 1)) - 1) || (sfull < -(1 << (w - 1)));
        ez    = (ed == 16'h0);
    endtask

    task automatic applyStimulus(input bit cfg, input logic v, input logic [15:0] av,
                                 input logic [15:0] bv, input logic bi);
        if (cfg) begin
            in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi;
        end else begin
            in_valid16 = v; a16 = av; b16 = bv; bin16 = bi;
        end
    endtask

    task automatic setReady(input bit cfg, input logic r);
        if (cfg) out_ready8 = r;
        else     out_ready16 = r;
    endtask

    function automatic logic getInReady(input bit cfg);
        return cfg ? in_ready8 : in_ready16;
    endfunction

    function automatic logic getOutValid(input bit cfg);
        return cfg ? out_valid8 : out_valid16;
    endfunction

    function automatic logic [15:0] getD(input bit cfg);
        return cfg ? {8'h00, d8} : d16;
    endfunction

    function automatic logic [2:0] getFlags(input bit cfg);
        return cfg ? {bout8, ovf8, zero8} : {bout16, ovf16, zero16};
    endfunction

    // Accepts one job, measures latency in edges and checks the completed result.
    task automatic issueJob(input bit cfg, input logic [15:0] av, input logic [15:0] bv,
                            input logic bi, input string tag, output bit ok);
        int          lat, guard, ndig;
        logic [15:0] ed;
        logic        eb, eo, ez;
        bit          done;
        ndig = cfg ? 1 : 4;
        refModel(cfg ? 8 : 16, av, bv, bi, ed, eb, eo, ez);
        ok = 1'b0;
        @(negedge clk);
        guard = 0;
        while (!getInReady(cfg) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput({tag, " in_ready_timeout"}, 32'(guard), 32'(0));
            return;
        end
        applyStimulus(cfg, 1'b1, av, bv, bi);
        @(posedge clk);
        #1;
        applyStimulus(cfg, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            done = getOutValid(cfg);
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(ndig));
        if (!done) return;
        checkOutput({tag, " d"},    32'(getD(cfg)),        32'(ed));
        checkOutput({tag, " bout"}, 32'(getFlags(cfg)[2]), 32'(eb));
        checkOutput({tag, " ovf"},  32'(getFlags(cfg)[1]), 32'(eo));
        checkOutput({tag, " zero"}, 32'(getFlags(cfg)[0]), 32'(ez));
        ok = 1'b1;
    endtask

    task automatic retireJob(input bit cfg, input string tag);
        logic [15:0] held;
        held = getD(cfg);
        setReady(cfg, 1'b1);
        @(posedge clk);
        #1;
        setReady(cfg, 1'b0);
        @(negedge clk);
        checkOutput({tag, " out_valid_after_retire"}, 32'(getOutValid(cfg)), 32'(0));
        checkOutput({tag, " in_ready_after_retire"},  32'(getInReady(cfg)),  32'(1));
        checkOutput({tag, " d_held_in_idle"},         32'(getD(cfg)),        32'(held));
    endtask

    task automatic runJob(input bit cfg, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input int stall, input string tag);
        bit ok;
        issueJob(cfg, av, bv, bi, tag, ok);
        if (!ok) return;
        repeat (stall) @(negedge clk);
        retireJob(cfg, tag);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
        setReady(1'b0, 1'b0);
        setReady(1'b1, 1'b0);
        #12;
        checkOutput("reset16 d",         32'(d16), 32'(0));
        checkOutput("reset16 flags",     32'({bout16, ovf16, zero16}), 32'(0));
        checkOutput("reset16 out_valid", 32'(out_valid16), 32'(0));
        checkOutput("reset16 in_ready",  32'(in_ready16), 32'(1));
        checkOutput("reset8 d",          32'(d8), 32'(0));
        checkOutput("reset8 out_valid",  32'(out_valid8), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        runJob(1'b0, 16'h1234, 16'h0234, 1'b0, 0, "t1");
        runJob(1'b0, 16'h0000, 16'h0001, 1'b0, 0, "t2a");
        runJob(1'b0, 16'h8000, 16'h0001, 1'b0, 1, "t2b");
        runJob(1'b0, 16'h0005, 16'h0004, 1'b1, 0, "t3a");
        runJob(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0, "t3b");
        runJob(1'b0, 16'hABCD, 16'hABCD, 1'b0, 0, "t3c");

        // Backpressure while a new job is being offered.
        issueJob(1'b0, 16'h4321, 16'h1111, 1'b0, "t4", ok);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                applyStimulus(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
                @(posedge clk);
                @(negedge clk);
                checkOutput("t4 stall d",         32'(d16), 32'(16'h3210));
                checkOutput("t4 stall out_valid", 32'(out_valid16), 32'(1));
                checkOutput("t4 stall in_ready",  32'(in_ready16), 32'(0));
            end
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            retireJob(1'b0, "t4");
            checkOutput("t4 final d", 32'(d16), 32'(16'h3210));
        end

        // Reset after the second RUN digit.
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 16'h0F0F, 16'h0101, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5 reset d",         32'(d16), 32'(0));
        checkOutput("t5 reset flags",     32'({bout16, ovf16, zero16}), 32'(0));
        checkOutput("t5 reset out_valid", 32'(out_valid16), 32'(0));
        checkOutput("t5 reset in_ready",  32'(in_ready16), 32'(1));
        @(negedge clk);
        rst_n = 1'b1;
        runJob(1'b0, 16'h00FF, 16'h000F, 1'b0, 0, "t5 post");

        runJob(1'b1, 16'h0080, 16'h0001, 1'b0, 0, "t6");
        runJob(1'b1, 16'h00FF, 16'h00FF, 1'b1, 0, "t6b");

        for (int i = 0; i < 1000; i++) begin
            runJob(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd16");
        end
        for (int i = 0; i < 1000; i++) begin
            runJob(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rnd8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
